vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the tile-lookup block. Generates the 640x480@60 VGA raster: pixel-rate strobe, hcount/vcount, active-low hsync/vsync, bright and a frame-start pulse.
- hcount/vcount/bright feed the tile-select stage directly. That stage computes column = (hcount-HLEFT-1)>>3 and row = (vcount-VTOP-1)>>3, so the bright window below is defined to match.

Parameters:
- CLK_DIV, 2, system clocks per pixel; must be >=1; default gives 25 MHz from 50 MHz.
- HSYNC, 96, hsync pulse width in pixels.
- HLEFT, 144, first hcount before the active region (sync + back porch).
- HPIXELS, 640, active pixels per line.
- HTOTAL, 800, pixels per line.
- VSYNC, 2, vsync pulse width in lines.
- VTOP, 31, first vcount before the active region.
- VLINES, 480, active lines.
- VTOTAL, 521, lines per frame.
- SYNC_DELAY, 1, pixel ticks of delay for the optional delayed outputs (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  out  1  one-clk strobe, once every CLK_DIV clocks
- hcount  out  10  horizontal pixel counter, 0..HTOTAL-1
- vcount  out  10  line counter, 0..VTOTAL-1
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- bright  out  1  high inside the visible window
- frame_start  out  1  one-clk pulse at frame wrap
- hsync_d  out  1  (VGA_SYNC_DELAY_EN only) delayed hsync
- vsync_d  out  1  (VGA_SYNC_DELAY_EN only) delayed vsync
- bright_d  out  1  (VGA_SYNC_DELAY_EN only) delayed bright

Behaviour:
- Reset values: div counter=0, pix_en=0, hcount=0, vcount=0, hsync=0, vsync=0, bright=0, frame_start=0, delay lines all 0.
- Reset applies on any clk edge with rst=1, including mid-line or mid-frame. The first pix_en comes CLK_DIV clocks after rst deasserts.
- Divider: counts 0..CLK_DIV-1. pix_en=1 for the clk in which the divider is at CLK_DIV-1; the divider wraps to 0 there. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counters advance only on the edge closing a pix_en cycle:
  - hcount increments; at HTOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after VTOTAL-1.
  - No other values are reachable.
- hsync, vsync and bright are registered. They are decoded from the next-count values, so they change on the same edge as hcount/vcount with zero skew:
  - hsync = 0 iff hcount < HSYNC.
  - vsync = 0 iff vcount < VSYNC.
  - bright = 1 iff HLEFT < hcount <= HLEFT+HPIXELS and VTOP < vcount <= VTOP+VLINES, i.e. hcount 145..784 and vcount 32..511.
- frame_start: registered, high for exactly one clk, on the edge where (hcount,vcount) become (0,0) from (HTOTAL-1,VTOTAL-1). Never asserted out of reset.
- Widths: all compares are 10-bit unsigned. Parameters must satisfy HLEFT+HPIXELS < HTOTAL <= 1024 and the equivalent vertical constraint; an elaboration-time check enforces this.

Optional Feature:
- Macro VGA_SYNC_DELAY_EN.
- Defined: hsync_d/vsync_d/bright_d ports exist. Each is its source passed through a SYNC_DELAY-deep shift register advanced only on pix_en. This aligns the syncs with the tile-lookup ROM read latency. Delay stages reset to 0.
- Undefined: the ports and registers are absent; other outputs are unchanged.

Decomposition:
- Shared package vga_pkg: 640x480 timing constants (HSYNC, HLEFT, HPIXELS, HTOTAL, VSYNC, VTOP, VLINES, VTOTAL) and the 10-bit count width, also reused by the tile-select and pixel stages.
- One natural sub-module: vga_pix_div (divider producing pix_en), reusable by the downstream pixel pipeline.

Test Plan:
- Reset release with CLK_DIV=2 -> pix_en pulses on clk 2,4,6,...; hcount 0->1 at the first pix_en; hsync=0, vsync=0, bright=0.
- Run one line -> hsync low for hcount 0..95, high 96..799; hcount 799 wraps to 0 and vcount increments by 1.
- Full frame -> bright high only for hcount 145..784 with vcount 32..511; count 640x480=307200 bright pixel ticks; vsync low for vcount 0..1.
- Frame wrap at (799,520) -> frame_start exactly one clk; one pulse per 416800 pixel ticks.
- Assert rst at hcount=400, vcount=200 for one clk -> next edge all outputs at reset values; timing restarts as in the first scenario.
- VGA_SYNC_DELAY_EN, SYNC_DELAY=1 -> bright_d rises exactly one pix_en tick after bright, at hcount=146 on line 32; hsync_d/vsync_d lag by one tick likewise.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 timing constants and the 10-bit raster count width.
// Used by the timing generator and by the downstream tile-select and pixel
// stages so every stage agrees on the raster geometry.
// Contents:
//   CNT_W                     width of hcount/vcount
//   HSYNC/HLEFT/HPIXELS/HTOTAL horizontal timing (pixels)
//   VSYNC/VTOP/VLINES/VTOTAL   vertical timing (lines)
//   in_window()               lo < c <= lo+len window test
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W   = 10;

  localparam int HSYNC   = 96;
  localparam int HLEFT   = 144;
  localparam int HPIXELS = 640;
  localparam int HTOTAL  = 800;

  localparam int VSYNC   = 2;
  localparam int VTOP    = 31;
  localparam int VLINES  = 480;
  localparam int VTOTAL  = 521;

  // Visible window is open at lo and closed at lo+len, so the tile-select
  // stage's (count-lo-1)>>3 starts at tile 0 on the first visible pixel.
  // The sum is formed one bit wider so lo+len can never wrap.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] len);
    logic [CNT_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (c > lo) && ({1'b0, c} <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// ---------------------------------------------------------------------------
// vga_pix_div
// Pixel-rate divider: counts 0..CLK_DIV-1 and raises pix_en for the single
// clk in which the counter sits at CLK_DIV-1. pix_en is registered, so it is
// 0 in the reset state even when CLK_DIV=1 (then it is constantly 1 after
// the first edge out of reset).
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   pix_en  out  one-clk strobe every CLK_DIV clocks
// ---------------------------------------------------------------------------
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;
  logic          pix_en_reg;

  always_comb begin
    div_next = div_reg + DW'(1);
    if (div_reg == LAST) begin
      div_next = '0;
    end
  end

  // pix_en is produced from the value the divider is about to hold, which
  // keeps it aligned with div_reg == LAST without a combinational output.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg    <= '0;
      pix_en_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      pix_en_reg <= (div_next == LAST);
    end
  end

  assign pix_en = pix_en_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 raster generator feeding the tile-lookup block.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pix_en       out  one-clk pixel strobe, every CLK_DIV clocks
//   hcount       out  pixel counter 0..HTOTAL-1
//   vcount       out  line counter 0..VTOTAL-1
//   hsync        out  active-low, low while hcount < HSYNC
//   vsync        out  active-low, low while vcount < VSYNC
//   bright       out  HLEFT < hcount <= HLEFT+HPIXELS and
//                     VTOP  < vcount <= VTOP+VLINES
//   frame_start  out  one-clk pulse when the raster wraps to (0,0)
//   hsync_d/vsync_d/bright_d  out  (VGA_SYNC_DELAY_EN) the above delayed by
//                     SYNC_DELAY pixel ticks, to line up with the tile ROM
// Optional feature macro: VGA_SYNC_DELAY_EN
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int HSYNC      = vga_pkg::HSYNC,
  parameter int HLEFT      = vga_pkg::HLEFT,
  parameter int HPIXELS    = vga_pkg::HPIXELS,
  parameter int HTOTAL     = vga_pkg::HTOTAL,
  parameter int VSYNC      = vga_pkg::VSYNC,
  parameter int VTOP       = vga_pkg::VTOP,
  parameter int VLINES     = vga_pkg::VLINES,
  parameter int VTOTAL     = vga_pkg::VTOTAL,
  parameter int SYNC_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      pix_en,
  output logic [vga_pkg::CNT_W-1:0] hcount,
  output logic [vga_pkg::CNT_W-1:0] vcount,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      bright,
  output logic                      frame_start
`ifdef VGA_SYNC_DELAY_EN
  ,
  output logic                      hsync_d,
  output logic                      vsync_d,
  output logic                      bright_d
`endif
);

  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNCW = CNT_W'(HSYNC);
  localparam logic [CNT_W-1:0] V_SYNCW = CNT_W'(VSYNC);
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(HLEFT);
  localparam logic [CNT_W-1:0] H_LEN   = CNT_W'(HPIXELS);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(VTOP);
  localparam logic [CNT_W-1:0] V_LEN   = CNT_W'(VLINES);

  // Reject geometries that would overflow the 10-bit counters or put the
  // visible window past the end of the line/frame.
  if (!(CLK_DIV >= 1 && HSYNC < HTOTAL && HLEFT + HPIXELS < HTOTAL &&
        HTOTAL <= (1 << CNT_W) && VSYNC < VTOTAL &&
        VTOP + VLINES < VTOTAL && VTOTAL <= (1 << CNT_W) &&
        SYNC_DELAY >= 1 && SYNC_DELAY <= 4)) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic             pix_en_w;
  logic [CNT_W-1:0] h_reg, h_next;
  logic [CNT_W-1:0] v_reg, v_next;
  logic             frame_next;
  logic             hsync_reg, vsync_reg, bright_reg, frame_start_reg;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en_w)
  );

  always_comb begin
    h_next     = h_reg;
    v_next     = v_reg;
    frame_next = 1'b0;
    if (pix_en_w) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        if (v_reg == V_LAST) begin
          v_next     = '0;
          frame_next = 1'b1;
        end else begin
          v_next = v_reg + CNT_W'(1);
        end
      end else begin
        h_next = h_reg + CNT_W'(1);
      end
    end
  end

  // Syncs and bright are decoded from the next-count values so they change
  // on the same edge as the counters: zero skew against hcount/vcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg           <= '0;
      v_reg           <= '0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      bright_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      hsync_reg       <= (h_next >= H_SYNCW);
      vsync_reg       <= (v_next >= V_SYNCW);
      bright_reg      <= in_window(h_next, H_LO, H_LEN) &&
                         in_window(v_next, V_LO, V_LEN);
      frame_start_reg <= frame_next;
    end
  end

  assign pix_en      = pix_en_w;
  assign hcount      = h_reg;
  assign vcount      = v_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign bright      = bright_reg;
  assign frame_start = frame_start_reg;

`ifdef VGA_SYNC_DELAY_EN
  // Shift registers advanced once per pixel tick; stage 0 captures the
  // value the source held during the tick that is closing.
  logic [SYNC_DELAY-1:0] hs_dly_reg, hs_dly_next;
  logic [SYNC_DELAY-1:0] vs_dly_reg, vs_dly_next;
  logic [SYNC_DELAY-1:0] br_dly_reg, br_dly_next;

  for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_dly
    if (gi == 0) begin : g_head
      assign hs_dly_next[gi] = hsync_reg;
      assign vs_dly_next[gi] = vsync_reg;
      assign br_dly_next[gi] = bright_reg;
    end else begin : g_tail
      assign hs_dly_next[gi] = hs_dly_reg[gi-1];
      assign vs_dly_next[gi] = vs_dly_reg[gi-1];
      assign br_dly_next[gi] = br_dly_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_dly_reg <= '0;
      vs_dly_reg <= '0;
      br_dly_reg <= '0;
    end else if (pix_en_w) begin
      hs_dly_reg <= hs_dly_next;
      vs_dly_reg <= vs_dly_next;
      br_dly_reg <= br_dly_next;
    end
  end

  assign hsync_d  = hs_dly_reg[SYNC_DELAY-1];
  assign vsync_d  = vs_dly_reg[SYNC_DELAY-1];
  assign bright_d = br_dly_reg[SYNC_DELAY-1];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances: u_dflt with the 640x480 defaults (CLK_DIV=2) and u_small
// with a shrunken raster (CLK_DIV=3) so many full frames fit in the run.
// The reference model tracks only "edges since reset" and "pixel ticks since
// reset"; every expected output is plain arithmetic on the tick number.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic       pe0, hs0, vs0, br0, fs0, hsd0, vsd0, brd0;
  logic       pe1, hs1, vs1, br1, fs1, hsd1, vsd1, brd1;
  logic [9:0] hc0, vc0, hc1, vc1;

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst0), .pix_en(pe0), .hcount(hc0), .vcount(vc0),
    .hsync(hs0), .vsync(vs0), .bright(br0), .frame_start(fs0)
`ifdef VGA_SYNC_DELAY_EN
    , .hsync_d(hsd0), .vsync_d(vsd0), .bright_d(brd0)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(3), .HSYNC(3), .HLEFT(5), .HPIXELS(10), .HTOTAL(20),
    .VSYNC(2), .VTOP(3), .VLINES(6), .VTOTAL(12), .SYNC_DELAY(2)
  ) u_small (
    .clk(clk), .rst(rst1), .pix_en(pe1), .hcount(hc1), .vcount(vc1),
    .hsync(hs1), .vsync(vs1), .bright(br1), .frame_start(fs1)
`ifdef VGA_SYNC_DELAY_EN
    , .hsync_d(hsd1), .vsync_d(vsd1), .bright_d(brd1)
`endif
  );

`ifndef VGA_SYNC_DELAY_EN
  assign {hsd0, vsd0, brd0, hsd1, vsd1, brd1} = '0;
`endif

  // Per-instance geometry, index 0 = u_dflt, 1 = u_small.
  int dv[2], ht[2], hsw[2], hl[2], hp[2], vt[2], vsw[2], vtp[2], vl[2], sd[2];

  // Model state.
  int k[2];   // edges since reset
  int n[2];   // pixel ticks since reset
  bit pe[2];  // expected pix_en
  bit fs[2];  // expected frame_start

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // {hsync, vsync, bright} for pixel tick t of instance i.
  function automatic logic [2:0] dec(input int i, input int t);
    int h, v;
    h = t % ht[i];
    v = (t / ht[i]) % vt[i];
    return {h >= hsw[i], v >= vsw[i],
            h > hl[i] && h <= hl[i] + hp[i] && v > vtp[i] && v <= vtp[i] + vl[i]};
  endfunction

  task automatic model_step(input int i, input bit r);
    if (r) begin
      k[i] = 0; n[i] = 0; pe[i] = 0; fs[i] = 0;
    end else begin
      k[i]++;
      fs[i] = 0;
      if (pe[i]) begin
        n[i]++;
        fs[i] = (n[i] % (ht[i] * vt[i]) == 0);
      end
      pe[i] = (k[i] % dv[i] == dv[i] - 1);
    end
  endtask

  task automatic check_inst(input int i, input logic p, input logic [9:0] hc,
                            input logic [9:0] vc, input logic hs, input logic vs,
                            input logic br, input logic f, input logic hsd,
                            input logic vsd, input logic brd);
    logic [2:0] e;
    e = dec(i, n[i]);
    check($sformatf("u%0d.pix_en", i), p, pe[i]);
    check($sformatf("u%0d.hcount", i), hc, n[i] % ht[i]);
    check($sformatf("u%0d.vcount", i), vc, (n[i] / ht[i]) % vt[i]);
    check($sformatf("u%0d.hsync", i), hs, e[2]);
    check($sformatf("u%0d.vsync", i), vs, e[1]);
    check($sformatf("u%0d.bright", i), br, e[0]);
    check($sformatf("u%0d.frame_start", i), f, fs[i]);
`ifdef VGA_SYNC_DELAY_EN
    e = (n[i] >= sd[i]) ? dec(i, n[i] - sd[i]) : 3'b000;
    check($sformatf("u%0d.hsync_d", i), hsd, e[2]);
    check($sformatf("u%0d.vsync_d", i), vsd, e[1]);
    check($sformatf("u%0d.bright_d", i), brd, e[0]);
`else
    if (hsd | vsd | brd) $display("unexpected delayed output activity");
`endif
  endtask

  task automatic cycle(input bit rnd_rst);
    @(posedge clk);
    model_step(0, rst0);
    model_step(1, rst1);
    #1;
    check_inst(0, pe0, hc0, vc0, hs0, vs0, br0, fs0, hsd0, vsd0, brd0);
    check_inst(1, pe1, hc1, vc1, hs1, vs1, br1, fs1, hsd1, vsd1, brd1);
    if (rnd_rst) begin
      rst0 = ($urandom_range(0, 299) == 0) || (rst0 && $urandom_range(0, 1) == 1);
      rst1 = ($urandom_range(0, 199) == 0) || (rst1 && $urandom_range(0, 1) == 1);
    end else begin
      rst0 = 1'b0;
      rst1 = 1'b0;
    end
  endtask

  initial begin
    int  since_fs, bcnt;
    bit  seen_fs;
    dv  = '{2, 3};   ht  = '{800, 20}; hsw = '{96, 3};  hl = '{144, 5};
    hp  = '{640, 10}; vt = '{521, 12}; vsw = '{2, 2};   vtp = '{31, 3};
    vl  = '{480, 6};  sd = '{1, 2};
    k = '{0, 0}; n = '{0, 0}; pe = '{0, 0}; fs = '{0, 0};
    since_fs = 0; bcnt = 0; seen_fs = 0;

    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) begin
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b1);
      #1;
      check_inst(0, pe0, hc0, vc0, hs0, vs0, br0, fs0, hsd0, vsd0, brd0);
      check_inst(1, pe1, hc1, vc1, hs1, vs1, br1, fs1, hsd1, vsd1, brd1);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Free run: default raster reaches visible lines 32..33, small raster
    // completes many frames; frame-level counts on the small one.
    for (int c = 0; c < 54000 && err_cnt < 40; c++) begin
      cycle(1'b0);
      if (fs1) begin
        if (seen_fs) begin
          check("u1.frame_period_clks", since_fs, 20 * 12 * 3);
          check("u1.bright_ticks", bcnt, 10 * 6);
        end
        seen_fs  = 1;
        since_fs = 0;
        bcnt     = 0;
      end
      since_fs++;
      if (pe1 && br1) bcnt++;
    end

    // Random synchronous resets, including mid-line and multi-cycle holds.
    for (int c = 0; c < 8000 && err_cnt < 40; c++) begin
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
